// File: rtl/rv_muldiv_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rv_muldiv_seq : sequential RV32M/RV64M multiply/divide, valid/ready I/O |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module rv_muldiv_seq #(
  parameter int XLEN      = 32,
  parameter int MUL_STEP  = 1,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [4:0]      i_rd,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_busy
);

  localparam int              CW       = $clog2(XLEN);
  localparam int              MW       = XLEN + MUL_STEP;
  localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q;      // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc_q;    // mul: {partial product, multiplier}; div: low half dividend->quotient
  logic [XLEN-1:0]   rem_q;
  logic              neg_q;
  logic              early_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;

  logic            accept_d;
  logic            is_div_d;
  logic            sgn1_d;
  logic            sgn2_d;
  logic            zero1_d;
  logic            zero2_d;
  logic            ovf_d;
  logic            neg_d;
  logic            early_d;
  logic [XLEN-1:0] mag1_d;
  logic [XLEN-1:0] mag2_d;
  logic [XLEN-1:0] early_res_d;

  assign o_ready  = (state_q == IDLE) | ((state_q == DONE) & i_ready);
  assign accept_d = i_valid & o_ready;
  assign o_valid  = (state_q == DONE);
  assign o_busy   = (state_q == CALC) | (state_q == FIX);
  assign o_result = result_q;
  assign o_rd     = rd_q;

  always_comb begin
    is_div_d = i_funct3[2];
    sgn1_d   = i_op1[XLEN-1] & (is_div_d ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11));
    sgn2_d   = i_op2[XLEN-1] & (is_div_d ? ~i_funct3[0] : ~i_funct3[1]);
    mag1_d   = sgn1_d ? -i_op1 : i_op1;
    mag2_d   = sgn2_d ? -i_op2 : i_op2;
    zero1_d  = (i_op1 == '0);
    zero2_d  = (i_op2 == '0);
    ovf_d    = is_div_d & ~i_funct3[0] & (i_op1 == MIN_NEG) & (&i_op2);
    // A zero divisor must yield an all-ones quotient even when not taking the early path.
    if (is_div_d) begin
      neg_d = i_funct3[1] ? sgn1_d : ((sgn1_d ^ sgn2_d) & ~zero2_d);
    end else begin
      neg_d = sgn1_d ^ sgn2_d;
    end
    early_d     = EARLY_OUT & (is_div_d ? (zero2_d | ovf_d) : (zero1_d | zero2_d));
    early_res_d = '0;
    if (is_div_d & zero2_d) begin
      early_res_d = i_funct3[1] ? i_op1 : '1;
    end else if (is_div_d & ovf_d) begin
      early_res_d = i_funct3[1] ? '0 : i_op1;
    end
  end

  logic [MUL_STEP-1:0] digit_d;
  logic [MW-1:0]       mul_sum_d;
  logic [XLEN:0]       div_sh_d;
  logic [XLEN:0]       div_trial_d;
  logic                div_ge_d;
  logic [2*XLEN-1:0]   acc_step_d;
  logic [XLEN-1:0]     rem_step_d;
  logic [2*XLEN-1:0]   prod_d;
  logic [XLEN-1:0]     quo_sel_d;
  logic [XLEN-1:0]     fix_res_d;

  always_comb begin
    digit_d     = acc_q[MUL_STEP-1:0];
    mul_sum_d   = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + MW'(a_q) * MW'(digit_d);
    div_sh_d    = {rem_q, acc_q[XLEN-1]};
    div_trial_d = div_sh_d - {1'b0, a_q};
    div_ge_d    = ~div_trial_d[XLEN];
    if (funct3_q[2]) begin
      acc_step_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge_d};
      rem_step_d = div_ge_d ? div_trial_d[XLEN-1:0] : div_sh_d[XLEN-1:0];
    end else begin
      acc_step_d = {mul_sum_d, acc_q[XLEN-1:MUL_STEP]};
      rem_step_d = rem_q;
    end
    prod_d    = neg_q ? -acc_q : acc_q;
    quo_sel_d = funct3_q[1] ? rem_q : acc_q[XLEN-1:0];
    if (funct3_q[2]) begin
      fix_res_d = neg_q ? -quo_sel_d : quo_sel_d;
    end else begin
      fix_res_d = (funct3_q[1:0] == 2'b00) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      early_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        CALC: begin
          acc_q <= acc_step_d;
          rem_q <= rem_step_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == (funct3_q[2] ? DIV_LAST : MUL_LAST)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (!early_q) begin
            result_q <= fix_res_d;
          end
          state_q <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
        end
      endcase
      // Trivial cases skip CALC; their result is already final when FIX passes through.
      if (accept_d) begin
        funct3_q <= i_funct3;
        rd_q     <= i_rd;
        neg_q    <= neg_d;
        early_q  <= early_d;
        cnt_q    <= '0;
        rem_q    <= '0;
        if (is_div_d) begin
          a_q   <= mag2_d;
          acc_q <= {{XLEN{1'b0}}, mag1_d};
        end else begin
          a_q   <= mag1_d;
          acc_q <= {{XLEN{1'b0}}, mag2_d};
        end
        if (early_d) begin
          result_q <= early_res_d;
          state_q  <= FIX;
        end else begin
          state_q <= CALC;
        end
      end
    end
  end

endmodule
`default_nettype wire
